// File: rtl/yarp_mem_arbiter.sv
// -----------------------------------------------------------------------------
// yarp_mem_arbiter
//
// Shared backing-memory arbiter for the YARP core. Two requesters, the I-cache
// (line refills, read only) and the D-cache (refill or writeback), are
// serialised onto one external memory port. Arbitration is round-robin at
// burst granularity, so once a burst is granted it runs to completion and the
// other requester gets the next tie.
//
// Each burst is BEATS aligned, incrementing DATA_W words. A burst walks through
// IDLE -> BURST -> DONE -> IDLE. The owner's gnt pulses in the first BURST
// cycle, and done pulses in the single DONE cycle. For reads, done coincides
// with the final rvalid.
//
// Ports
//   clk, reset         : single clock (rising edge) and synchronous active-high
//                        reset. While reset is applied, every output is 0.
//   ic_req_i/ic_addr_i : I-cache line refill request and line address.
//   ic_gnt_o           : one-cycle pulse, I-cache request accepted.
//   ic_rvalid_o/rdata_o: I-cache read beat, one cycle after the memory beat.
//   ic_done_o          : one-cycle pulse with the final I-cache beat.
//   dc_req_i/dc_we_i   : D-cache burst request; we (1 = writeback) is sampled
//                        at grant.
//   dc_addr_i          : D-cache line address.
//   dc_wdata_i         : current writeback beat; the D-cache advances it on
//                        dc_wready_o.
//   dc_gnt_o           : one-cycle pulse, D-cache request accepted.
//   dc_wready_o        : write beat consumed this cycle (combinational).
//   dc_rvalid_o/rdata_o: D-cache read beat, one cycle after the memory beat.
//   dc_done_o          : one-cycle pulse at the end of a D-cache burst.
//   mem_*              : beat-level memory port. mem_ready_i completes the
//                        current beat; read data is valid with it.
// -----------------------------------------------------------------------------
module yarp_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  // I-cache side
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_gnt_o,
  output logic              ic_rvalid_o,
  output logic [DATA_W-1:0] ic_rdata_o,
  output logic              ic_done_o,
  // D-cache side
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_gnt_o,
  output logic              dc_wready_o,
  output logic              dc_rvalid_o,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              dc_done_o,
  // Memory side
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // Beat counter width and the byte-offset width of one line.
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OFF_W  = CNT_W + 2;
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Requester indices into the per-requester vectors below.
  localparam int NREQ   = 2;
  localparam int REQ_IC = 0;
  localparam int REQ_DC = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic                owner_q;       // 1 = D-cache owns the current burst
  logic                we_q;          // current burst is a writeback
  logic                last_grant_q;  // 1 = D-cache won the most recent grant
  logic [LINE_W-1:0]   line_q;        // line-aligned part of the burst address
  logic [CNT_W-1:0]    beat_cnt_q;
  logic [NREQ-1:0]     gnt_q;
  logic [NREQ-1:0]     done_q;

  // ---------------------------------------------------------------------------
  // Next-state helpers
  // ---------------------------------------------------------------------------
  logic                req_any_d;
  logic                pick_dc_d;
  logic [LINE_W-1:0]   line_d;
  logic [CNT_W-1:0]    beat_cnt_d;
  logic                in_burst;
  logic                last_beat;
  logic                rd_ack;
  logic [NREQ-1:0]     owner_oh;

  always_comb begin
    req_any_d  = ic_req_i | dc_req_i;
    // The D-cache wins when it is the only requester, or on a tie when the
    // I-cache took the previous grant.
    pick_dc_d  = dc_req_i & (~ic_req_i | ~last_grant_q);
    line_d     = pick_dc_d ? dc_addr_i[ADDR_W-1:OFF_W] : ic_addr_i[ADDR_W-1:OFF_W];
    beat_cnt_d = beat_cnt_q + 1'b1;
    in_burst   = (state_q == ST_BURST);
    last_beat  = (beat_cnt_q == LAST_BEAT);
    // A read beat is accepted by memory this cycle.
    rd_ack     = in_burst & mem_ready_i & ~we_q;
    owner_oh   = {owner_q, ~owner_q};
  end

  // The byte offset inside a line is ignored: bursts always start at beat 0.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{ic_addr_i[OFF_W-1:0], dc_addr_i[OFF_W-1:0]};

  // ---------------------------------------------------------------------------
  // Burst sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;   // D-cache, so the I-cache wins the first tie
      line_q       <= '0;
      beat_cnt_q   <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
    end else begin
      // gnt and done are single-cycle pulses unless re-armed below.
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_any_d) begin
            owner_q      <= pick_dc_d;
            last_grant_q <= pick_dc_d;
            we_q         <= pick_dc_d & dc_we_i;
            line_q       <= line_d;
            beat_cnt_q   <= '0;
            gnt_q        <= pick_dc_d ? 2'b10 : 2'b01;
            state_q      <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (mem_ready_i) begin
            // Wraps to 0 after the last beat, which is never observed.
            beat_cnt_q <= beat_cnt_d;
            if (last_beat) begin
              done_q  <= owner_oh;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path: one registered copy of the memory beat per requester,
  // loaded only for the current owner so the other side stays quiet.
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0]   rvalid_w;
  logic [DATA_W-1:0] rdata_w [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rd
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rd_ack & owner_oh[gi];
        rdata_q  <= (rd_ack & owner_oh[gi]) ? mem_rdata_i : '0;
      end
    end

    assign rvalid_w[gi] = rvalid_q;
    assign rdata_w[gi]  = rdata_q;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ic_gnt_o    = gnt_q[REQ_IC];
  assign ic_done_o   = done_q[REQ_IC];
  assign ic_rvalid_o = rvalid_w[REQ_IC];
  assign ic_rdata_o  = rdata_w[REQ_IC];

  assign dc_gnt_o    = gnt_q[REQ_DC];
  assign dc_done_o   = done_q[REQ_DC];
  assign dc_rvalid_o = rvalid_w[REQ_DC];
  assign dc_rdata_o  = rdata_w[REQ_DC];

  // Write beats are consumed in the same cycle memory accepts them, so the
  // D-cache can present the next word on the following cycle.
  assign dc_wready_o = in_burst & mem_ready_i & owner_q & we_q;

  // Memory port is driven only during BURST; everything else reads as 0.
  assign mem_req_o   = in_burst;
  assign mem_we_o    = in_burst & we_q;
  assign mem_addr_o  = in_burst ? {line_q, beat_cnt_q, 2'b00} : '0;
  assign mem_wdata_o = (in_burst & we_q) ? dc_wdata_i : '0;

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Self-checking bench for yarp_mem_arbiter. Expected behaviour comes from a
// burst-level model: line base + 4*beat addresses, data as a function of the
// address, round-robin winner tracked as "whoever did not win last time",
// rvalid one cycle after each accepted read beat, done in the cycle after the
// final beat, IDLE one cycle later.
module tb_yarp_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEATS  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              ic_req_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_gnt_o;
  logic              ic_rvalid_o;
  logic [DATA_W-1:0] ic_rdata_o;
  logic              ic_done_o;
  logic              dc_req_i;
  logic              dc_we_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic [DATA_W-1:0] dc_wdata_i;
  logic              dc_gnt_o;
  logic              dc_wready_o;
  logic              dc_rvalid_o;
  logic [DATA_W-1:0] dc_rdata_o;
  logic              dc_done_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;

  always #5 clk = ~clk;

  yarp_mem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .BEATS (BEATS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ic_req_i   (ic_req_i),
    .ic_addr_i  (ic_addr_i),
    .ic_gnt_o   (ic_gnt_o),
    .ic_rvalid_o(ic_rvalid_o),
    .ic_rdata_o (ic_rdata_o),
    .ic_done_o  (ic_done_o),
    .dc_req_i   (dc_req_i),
    .dc_we_i    (dc_we_i),
    .dc_addr_i  (dc_addr_i),
    .dc_wdata_i (dc_wdata_i),
    .dc_gnt_o   (dc_gnt_o),
    .dc_wready_o(dc_wready_o),
    .dc_rvalid_o(dc_rvalid_o),
    .dc_rdata_o (dc_rdata_o),
    .dc_done_o  (dc_done_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_seen = 0;
  logic [31:0] data_key;
  bit          last_dc;   // model: 1 if the D-cache won the most recent grant

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~(32'(BEATS * 4) - 32'd1);
  endfunction

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ data_key;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ ~data_key;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk1 ({tag, "_ic_gnt"},    ic_gnt_o,    1'b0);
    chk1 ({tag, "_ic_rvalid"}, ic_rvalid_o, 1'b0);
    chk32({tag, "_ic_rdata"},  ic_rdata_o,  32'h0);
    chk1 ({tag, "_ic_done"},   ic_done_o,   1'b0);
    chk1 ({tag, "_dc_gnt"},    dc_gnt_o,    1'b0);
    chk1 ({tag, "_dc_wready"}, dc_wready_o, 1'b0);
    chk1 ({tag, "_dc_rvalid"}, dc_rvalid_o, 1'b0);
    chk32({tag, "_dc_rdata"},  dc_rdata_o,  32'h0);
    chk1 ({tag, "_dc_done"},   dc_done_o,   1'b0);
    chk1 ({tag, "_mem_req"},   mem_req_o,   1'b0);
    chk1 ({tag, "_mem_we"},    mem_we_o,    1'b0);
    chk32({tag, "_mem_addr"},  mem_addr_o,  32'h0);
    chk32({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
  endtask

  // Called at the sample point of the cycle in which the winning request is
  // presented to an IDLE arbiter. Follows the burst through DONE and returns
  // at the sample point of the following IDLE cycle.
  // mode: 0 = memory always ready, 1 = ready on every other cycle (low first),
  //       2 = random wait states.
  task automatic expect_burst(input bit is_dc, input bit we, input logic [31:0] addr,
                              input int mode, input bit hold_req, input int raise_dc_at);
    int          k;
    int          cyc;
    bit          rdy;
    bit          prev_ack;
    logic [31:0] prev_data;
    logic [31:0] ea;
    k         = 0;
    cyc       = 0;
    prev_ack  = 1'b0;
    prev_data = 32'h0;
    tick();
    if (!hold_req) begin
      if (is_dc) dc_req_i = 1'b0;
      else       ic_req_i = 1'b0;
    end
    while (k < BEATS && cyc < 200) begin
      ea = line_base(addr) + 32'(4 * k);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 2) == 1);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (cyc == raise_dc_at) dc_req_i = 1'b1;
      mem_ready_i = rdy;
      mem_rdata_i = rdata_of(ea);
      dc_wdata_i  = wdata_of(ea);
      #1;
      chk1 ("ic_gnt",    ic_gnt_o,    !is_dc && cyc == 0);
      chk1 ("dc_gnt",    dc_gnt_o,    is_dc && cyc == 0);
      chk1 ("mem_req",   mem_req_o,   1'b1);
      chk1 ("mem_we",    mem_we_o,    we);
      chk32("mem_addr",  mem_addr_o,  ea);
      chk1 ("dc_wready", dc_wready_o, rdy & is_dc & we);
      if (we) chk32("mem_wdata", mem_wdata_o, wdata_of(ea));
      chk1 ("ic_rvalid", ic_rvalid_o, prev_ack & !is_dc);
      chk1 ("dc_rvalid", dc_rvalid_o, prev_ack & is_dc);
      if (prev_ack) chk32("rdata", is_dc ? dc_rdata_o : ic_rdata_o, prev_data);
      chk1 ("ic_done",   ic_done_o,   1'b0);
      chk1 ("dc_done",   dc_done_o,   1'b0);
      if (dc_wready_o) wr_seen++;
      prev_ack  = rdy & !we;
      prev_data = rdata_of(ea);
      if (rdy) k++;
      cyc++;
      tick();
    end
    mem_ready_i = 1'b0;
    #1;
    // DONE cycle
    chk1 ("done_ic",      ic_done_o,   !is_dc);
    chk1 ("done_dc",      dc_done_o,   is_dc);
    chk1 ("done_ic_rv",   ic_rvalid_o, prev_ack & !is_dc);
    chk1 ("done_dc_rv",   dc_rvalid_o, prev_ack & is_dc);
    if (prev_ack) chk32("done_rdata", is_dc ? dc_rdata_o : ic_rdata_o, prev_data);
    chk1 ("done_mem_req", mem_req_o,   1'b0);
    chk1 ("done_wready",  dc_wready_o, 1'b0);
    chk1 ("done_ic_gnt",  ic_gnt_o,    1'b0);
    chk1 ("done_dc_gnt",  dc_gnt_o,    1'b0);
    tick();
    // IDLE cycle
    chk1 ("idle_ic_done", ic_done_o,   1'b0);
    chk1 ("idle_dc_done", dc_done_o,   1'b0);
    chk1 ("idle_ic_rv",   ic_rvalid_o, 1'b0);
    chk1 ("idle_dc_rv",   dc_rvalid_o, 1'b0);
    chk1 ("idle_mem_req", mem_req_o,   1'b0);
    chk1 ("idle_ic_gnt",  ic_gnt_o,    1'b0);
    chk1 ("idle_dc_gnt",  dc_gnt_o,    1'b0);
    last_dc = is_dc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          nxt;
    bit          w;
    int          sel;
    logic [31:0] ia;
    logic [31:0] da;

    reset       = 1'b1;
    ic_req_i    = 1'b0;
    ic_addr_i   = '0;
    dc_req_i    = 1'b0;
    dc_we_i     = 1'b0;
    dc_addr_i   = '0;
    dc_wdata_i  = '0;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    data_key    = 32'h0;
    last_dc     = 1'b1;

    // Reset state
    repeat (2) tick();
    check_all_zero("rst");

    // Simultaneous requests held continuously: I, D, I, D
    ic_addr_i = 32'h0000_4010;
    dc_addr_i = 32'h0000_5020;
    dc_we_i   = 1'b0;
    reset     = 1'b0;
    ic_req_i  = 1'b1;
    dc_req_i  = 1'b1;
    for (int r = 0; r < 4; r++) begin
      nxt = !last_dc;
      chk1("rr_expected_order", nxt, (r % 2) == 1);
      expect_burst(nxt, 1'b0, nxt ? dc_addr_i : ic_addr_i, 0, 1'b1, -1);
    end
    ic_req_i = 1'b0;
    dc_req_i = 1'b0;

    // Single I-cache refill, data = address
    data_key  = 32'h0;
    ic_addr_i = 32'h0000_1004;
    ic_req_i  = 1'b1;
    expect_burst(1'b0, 1'b0, 32'h0000_1004, 0, 1'b0, -1);

    // D-cache writeback with memory ready every other cycle
    data_key  = 32'h1234_5678;
    dc_addr_i = 32'h0000_2000;
    dc_we_i   = 1'b1;
    wr_seen   = 0;
    dc_req_i  = 1'b1;
    expect_burst(1'b1, 1'b1, 32'h0000_2000, 1, 1'b0, -1);
    chk32("wready_count", 32'(wr_seen), 32'(BEATS));
    dc_we_i   = 1'b0;

    // D-cache request rising in the middle of an I-cache burst
    ic_addr_i = 32'h0000_6000;
    dc_addr_i = 32'h0000_7004;
    ic_req_i  = 1'b1;
    expect_burst(1'b0, 1'b0, 32'h0000_6000, 0, 1'b0, 2);
    expect_burst(1'b1, 1'b0, 32'h0000_7004, 0, 1'b0, -1);

    // Requester drops after grant, random wait states
    data_key  = 32'hCAFE_0000;
    ic_addr_i = 32'h0000_8ABC;
    ic_req_i  = 1'b1;
    expect_burst(1'b0, 1'b0, 32'h0000_8ABC, 2, 1'b0, -1);

    // Reset after two beats of a D-cache refill, request kept pending
    dc_addr_i   = 32'h0000_3000;
    dc_we_i     = 1'b0;
    dc_req_i    = 1'b1;
    tick();                 // grant cycle, beat 0
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h0BAD_0000;
    tick();                 // beat 1
    tick();                 // beat 2 presented
    #1;
    chk32("mid_addr", mem_addr_o, 32'h0000_3008);
    reset       = 1'b1;
    mem_ready_i = 1'b0;
    tick();
    check_all_zero("rst_mid");
    reset   = 1'b0;
    last_dc = 1'b1;
    expect_burst(1'b1, 1'b0, 32'h0000_3000, 0, 1'b0, -1);

    // Randomized traffic against the burst-level model
    for (int i = 0; i < 24; i++) begin
      sel       = int'($urandom_range(0, 2));
      ia        = $urandom;
      da        = $urandom;
      w         = 1'($urandom_range(0, 1));
      data_key  = $urandom;
      ic_addr_i = ia;
      dc_addr_i = da;
      dc_we_i   = w;
      case (sel)
        0: begin
          ic_req_i = 1'b1;
          expect_burst(1'b0, 1'b0, ia, 2, 1'b0, -1);
        end
        1: begin
          dc_req_i = 1'b1;
          expect_burst(1'b1, w, da, 2, 1'b0, -1);
        end
        default: begin
          ic_req_i = 1'b1;
          dc_req_i = 1'b1;
          nxt = !last_dc;
          expect_burst(nxt, nxt & w, nxt ? da : ia, 2, 1'b0, -1);
          expect_burst(!nxt, !nxt & w, !nxt ? da : ia, 2, 1'b0, -1);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/yarp_mem_arbiter.md
# yarp_mem_arbiter

Shared backing-memory arbiter for the YARP core. It serialises line-sized burst transfers from two requesters onto the single external memory port:
- I-cache refill (read only).
- D-cache refill or writeback (read or write).

Arbitration is round-robin at burst granularity, so neither cache starves. The block sits between the two cache tops and the memory model, and owns all sequencing of the memory port.

## Interface
Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width; one beat is one DATA_W word.
- BEATS, 4, words per cache line. Power of two, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ic_req_i  in  1  I-cache line refill request; held until ic_gnt_o.
- ic_addr_i  in  ADDR_W  I-cache line address; low log2(BEATS*4) bits ignored.
- ic_gnt_o  out  1  one-cycle pulse: I-cache request accepted.
- ic_rvalid_o  out  1  I-cache read beat valid.
- ic_rdata_o  out  DATA_W  I-cache read beat data.
- ic_done_o  out  1  one-cycle pulse with the final I-cache beat.
- dc_req_i  in  1  D-cache burst request; held until dc_gnt_o.
- dc_we_i  in  1  1 = writeback, 0 = refill; sampled at grant.
- dc_addr_i  in  ADDR_W  D-cache line address.
- dc_wdata_i  in  DATA_W  current writeback beat; advanced by the D-cache on dc_wready_o.
- dc_gnt_o  out  1  one-cycle pulse: D-cache request accepted.
- dc_wready_o  out  1  current write beat consumed this cycle.
- dc_rvalid_o  out  1  D-cache read beat valid.
- dc_rdata_o  out  DATA_W  D-cache read beat data.
- dc_done_o  out  1  one-cycle pulse at burst end (read or write).
- mem_req_o  out  1  beat request to memory.
- mem_we_o  out  1  beat is a write.
- mem_addr_o  out  ADDR_W  word address of the current beat.
- mem_wdata_o  out  DATA_W  write data; equals dc_wdata_i.
- mem_ready_i  in  1  beat completes this cycle; read data valid on mem_rdata_i.
- mem_rdata_i  in  DATA_W  read data.

## Operation
- FSM states are IDLE, BURST and DONE.
- **IDLE**
  - If exactly one request is high, latch that owner, its line address and we (we = 0 for the I-cache), clear beat_cnt, then go to BURST.
  - If both are high, grant the requester that is not last_grant. last_grant updates at each grant.
  - If neither is high, stay in IDLE.
- **BURST**
  - In the first BURST cycle, assert the owner's gnt_o.
  - mem_req_o = 1 throughout BURST.
  - mem_we_o = latched we.
  - mem_addr_o = {line_addr[ADDR_W-1:log2(BEATS*4)], beat_cnt, 2'b00}. Bursts are aligned and incrementing, with no wrap or critical-word-first.
  - On mem_ready_i, beat_cnt increments.
  - On mem_ready_i when beat_cnt == BEATS-1, go to DONE.
  - If mem_ready_i is low, hold all outputs and stay in BURST.
- **Reads:** the owner's rvalid_o and rdata_o are registered copies of (mem_ready_i, mem_rdata_i). They appear one cycle after each accepted beat.
- **Writes:** dc_wready_o = mem_ready_i & owner==DC & we. It is combinational. No rvalid is produced for writes.
- **DONE:** assert the owner's done_o for one cycle, coincident with the last rvalid on reads. Then go to IDLE.
- Requests arriving during BURST or DONE wait and are not lost.
- A requester deasserting its request mid-burst has no effect; the burst completes.
- **Reset:** state = IDLE, beat_cnt = 0, last_grant = DC (so the I-cache wins the first tie). All outputs are 0. No done pulse is emitted for an aborted burst.

## Timing
- Output values under reset: every output is 0.
- Grant latency: request seen in IDLE at cycle t gives gnt_o at t+1.
- Minimum burst (mem_ready_i always 1), request at cycle t:
  - mem_req_o is high t+1..t+BEATS.
  - Read rvalid is high t+2..t+BEATS+1.
  - done_o is at t+BEATS+1 (DONE).
  - IDLE is at t+BEATS+2.
  - Next grant is no earlier than t+BEATS+3.
- Memory wait states stretch BURST cycle-for-cycle. rvalid stays exactly one cycle behind each mem_ready_i.
- beat_cnt is log2(BEATS) bits. It wraps to 0 only after the last beat, which is unobservable.

## Test plan
- **Single I-cache refill:** BEATS=4, ic_addr_i=0x1004, mem_ready_i=1, mem_rdata_i = address. Expect:
  - gnt at t+1.
  - mem_addr_o = 0x1000, 0x1004, 0x1008, 0x100C.
  - ic_rdata_o follows the same sequence on t+2..t+5.
  - ic_done_o at t+5.
- **D-cache writeback with wait states:** dc_we_i=1, addr 0x2000, mem_ready_i low on every other cycle. Expect:
  - Exactly 4 dc_wready_o pulses.
  - Each write lands at 0x2000, 0x2004, 0x2008, 0x200C with the matching dc_wdata_i.
  - dc_done_o one cycle after the 4th.
  - No dc_rvalid_o.
- **Simultaneous requests after reset:** I-cache granted first, D-cache second. Both held continuously, so grants alternate I, D, I, D.
- **Request during burst:** dc_req_i rises mid I-cache burst. Expect dc_gnt_o exactly 2 cycles after ic_done_o, and no overlap of mem transactions.
- **Reset mid-burst:** assert reset after 2 beats. Next cycle expect:
  - All outputs 0 and state IDLE.
  - No done pulse.
  - After reset, a pending dc_req_i restarts from beat 0.
- **Requester drop:** deassert ic_req_i after ic_gnt_o. Expect all 4 beats and ic_done_o still delivered.
